// File: rtl/led_blink_coder_pkg.sv
// led_blink_coder_pkg: shared state encoding and counter width for the blink-code LED driver
package led_blink_coder_pkg;
  typedef enum logic [1:0] {IDLE, ON, OFF, GAP} state_t;
  localparam int MS_W = 16;
endpackage

// File: rtl/led_blink_coder_ms_tick_gen.sv
// ms_tick_gen: prescaler emitting a 1-cycle tick every TICKS cycles, synchronously clearable
module ms_tick_gen #(
  parameter int TICKS = 10
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  output logic tick
);
  localparam int W = TICKS > 1 ? $clog2(TICKS) : 1;
  logic [W-1:0] cnt_q, cnt_d;
  always_comb begin
    tick  = cnt_q == W'(TICKS - 1);
    cnt_d = (clr || tick) ? '0 : cnt_q + W'(1);
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt_q <= '0;
    else cnt_q <= cnt_d;
endmodule

// File: rtl/led_blink_coder.sv
// led_blink_coder: shows a status code as a burst of N blinks followed by a dark gap
module led_blink_coder
  import led_blink_coder_pkg::*;
#(
  parameter int CLOCK_FREQ = 100000000,
  parameter int CODE_W     = 4,
  parameter int ON_MS      = 200,
  parameter int OFF_MS     = 200,
  parameter int GAP_MS     = 1000
) (
  input  logic              CLK,
  input  logic              RESETN,
  input  logic [CODE_W-1:0] CODE,
  input  logic              CODE_VALID,
  output logic              CODE_READY,
  output logic              LED,
  output logic              BUSY
);
  localparam int TICKS_PER_MS = CLOCK_FREQ / 1000;
  localparam logic [CODE_W-1:0] CODE_OFF   = '0;
  localparam logic [CODE_W-1:0] CODE_SOLID = '1;
  localparam logic [MS_W-1:0] ON_END  = MS_W'(ON_MS - 1);
  localparam logic [MS_W-1:0] OFF_END = MS_W'(OFF_MS - 1);
  localparam logic [MS_W-1:0] GAP_END = MS_W'(GAP_MS - 1);
  state_t            state_q, state_d;
  logic [CODE_W-1:0] pending_q, pending_d, cur_q, cur_d, blink_q, blink_d, start_code;
  logic [MS_W-1:0]   ms_q, ms_d;
  logic              led_q, led_d, ready_q, accept, start, active, clr, tick;
  ms_tick_gen #(.TICKS(TICKS_PER_MS)) u_tick (
    .clk  (CLK),
    .rst_n(RESETN),
    .clr  (clr),
    .tick (tick)
  );
  always_comb begin
    accept     = CODE_VALID && ready_q;
    pending_d  = accept ? CODE : pending_q;
    state_d    = state_q;
    cur_d      = cur_q;
    blink_d    = blink_q;
    led_d      = led_q;
    start      = 1'b0;
    start_code = pending_q;
    case (state_q)
      IDLE: start = 1'b1;
      ON: if (tick && ms_q == ON_END) begin
        state_d = blink_q == cur_q ? GAP : OFF;
        led_d   = 1'b0;
      end
      OFF: if (tick && ms_q == OFF_END) begin
        state_d = ON;
        led_d   = 1'b1;
        blink_d = blink_q + CODE_W'(1);
      end
      GAP: if (tick && ms_q == GAP_END) begin
        start      = 1'b1;
        start_code = pending_d;
      end
      default: state_d = IDLE;
    endcase
    // a code accepted on the gap-expiry edge bypasses pending straight into the next burst
    active = start_code != CODE_OFF && start_code != CODE_SOLID;
    if (start) begin
      cur_d   = start_code;
      blink_d = CODE_W'(active);
      state_d = active ? ON : IDLE;
      led_d   = active || start_code == CODE_SOLID;
    end
    clr  = start || state_d != state_q;
    ms_d = clr ? '0 : ms_q + MS_W'(tick);
  end
  always_ff @(posedge CLK or negedge RESETN)
    if (!RESETN) begin
      state_q   <= IDLE;
      pending_q <= '0;
      cur_q     <= '0;
      blink_q   <= '0;
      ms_q      <= '0;
      led_q     <= 1'b0;
      ready_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      cur_q     <= cur_d;
      blink_q   <= blink_d;
      ms_q      <= ms_d;
      led_q     <= led_d;
      ready_q   <= 1'b1;
    end
  assign CODE_READY = ready_q;
  assign LED        = led_q;
  assign BUSY       = state_q != IDLE;
endmodule

// File: tb/tb_led_blink_coder.sv
// tb_led_blink_coder: directed LED waveform checks at 10 cycles/ms, ON=2, OFF=2, GAP=5 ms
module tb_led_blink_coder;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] code = '0;
  logic       code_valid = 1'b0;
  logic       code_ready, led, busy;
  int         errors = 0;
  int         checks = 0;
  led_blink_coder #(
    .CLOCK_FREQ(10000),
    .CODE_W    (4),
    .ON_MS     (2),
    .OFF_MS    (2),
    .GAP_MS    (5)
  ) dut (
    .CLK       (clk),
    .RESETN    (rst_n),
    .CODE      (code),
    .CODE_VALID(code_valid),
    .CODE_READY(code_ready),
    .LED       (led),
    .BUSY      (busy)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic run(input string tag, input bit exp_led, input bit exp_busy, input int n);
    for (int i = 0; i < n; i++) begin
      step();
      check({tag, "_led"}, int'(led), int'(exp_led));
      check({tag, "_busy"}, int'(busy), int'(exp_busy));
      check({tag, "_ready"}, int'(code_ready), 1);
    end
  endtask
  task automatic accept(input string tag, input logic [3:0] c, input bit exp_led);
    code       = c;
    code_valid = 1'b1;
    step();
    code_valid = 1'b0;
    check({tag, "_acc_led"}, int'(led), int'(exp_led));
  endtask
  initial begin
    #12;
    check("rst_led", int'(led), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_ready", int'(code_ready), 0);
    #11 rst_n = 1'b1;
    #1 check("rel_ready_pre", int'(code_ready), 0);
    step();
    check("rel_ready", int'(code_ready), 1);
    run("idle", 0, 0, 10);
    // code 3: 20/20/20/20/20 then 50 dark, twice
    accept("c3", 4'd3, 0);
    for (int p = 0; p < 2; p++) begin
      run("c3_on1", 1, 1, 20);
      run("c3_off1", 0, 1, 20);
      run("c3_on2", 1, 1, 20);
      run("c3_off2", 0, 1, 20);
      run("c3_on3", 1, 1, 20);
      run("c3_gap", 0, 1, 50);
    end
    // code 1 accepted mid second blink: current burst still completes
    run("c3b_on1", 1, 1, 20);
    run("c3b_off1", 0, 1, 20);
    run("c3b_on2a", 1, 1, 10);
    accept("c1", 4'd1, 1);
    run("c3b_on2b", 1, 1, 9);
    run("c3b_off2", 0, 1, 20);
    run("c3b_on3", 1, 1, 20);
    run("c3b_gap", 0, 1, 50);
    for (int p = 0; p < 2; p++) begin
      run("c1_on", 1, 1, 20);
      run("c1_gap", 0, 1, 50);
    end
    // code 2 accepted on the gap-expiry edge takes effect immediately
    run("c1_on_last", 1, 1, 20);
    run("c1_gap_last", 0, 1, 50);
    accept("c2", 4'd2, 1);
    run("c2_on1", 1, 1, 19);
    run("c2_off1", 0, 1, 20);
    run("c2_on2", 1, 1, 20);
    run("c2_gap", 0, 1, 50);
    run("c2_on1b", 1, 1, 5);
    // asynchronous reset in the middle of an ON phase
    #2 rst_n = 1'b0;
    #1;
    check("arst_led", int'(led), 0);
    check("arst_busy", int'(busy), 0);
    check("arst_ready", int'(code_ready), 0);
    #3 rst_n = 1'b1;
    step();
    check("arel_ready", int'(code_ready), 1);
    check("arel_led", int'(led), 0);
    run("arel_idle", 0, 0, 40);
    // solid-on and off codes are held in IDLE
    accept("c15", 4'd15, 0);
    run("c15_solid", 1, 0, 30);
    accept("c0", 4'd0, 1);
    run("c0_dark", 0, 0, 30);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
